hilo_div_ctrl: RTL and testbench
================================

# hilo_div_ctrl

Execute-stage control for multi-cycle divides and the HI/LO register pair. The block accepts DIV, DIVU, MTHI and MTLO operations from the EX stage and drives the start/annul/operand handshake of the iterative divider. It stalls the pipeline while a divide is in flight, commits the 64-bit divider result into HI/LO, and handles pipeline flushes by annulling the divide.

## Interface
- Parameters: none.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_i  in  3  0 = NOP, 1 = DIV, 2 = DIVU, 3 = MTHI, 4 = MTLO; 5..7 are treated as NOP
- rs_i  in  32  dividend, or write data for MTHI/MTLO
- rt_i  in  32  divisor
- flush_i  in  1  pipeline flush; kills the current op
- div_start_o  out  1  divider start/hold; reset 0
- div_annul_o  out  1  divider cancel; reset 0
- div_signed_o  out  1  1 for DIV; reset 0
- div_op1_o  out  32  latched dividend; reset 0
- div_op2_o  out  32  latched divisor; reset 0
- div_result_i  in  64  [63:32] remainder, [31:0] quotient
- div_ready_i  in  1  divider result valid
- stall_o  out  1  hold EX and all earlier stages; 0 in reset
- hi_o  out  32  HI register; reset 0
- lo_o  out  32  LO register; reset 0

## Operation
- FSM states:
  - IDLE: div_start_o = 0.
  - BUSY: div_start_o = 1.
  - DONE: div_start_o = 0.
- IDLE, op DIV/DIVU, flush_i = 0:
  - Register rs_i/rt_i into div_op1_o/div_op2_o.
  - Register div_signed_o = (op == DIV).
  - Go to BUSY.
- IDLE, op MTHI (MTLO), flush_i = 0: hi_o (lo_o) <= rs_i at the edge; state stays IDLE.
- IDLE with flush_i = 1: no register or state change.
- BUSY, flush_i = 0, div_ready_i = 1:
  - hi_o <= div_result_i[63:32], lo_o <= div_result_i[31:0].
  - Go to DONE.
- BUSY, flush_i = 0, div_ready_i = 0: stay in BUSY; operands are held stable.
- BUSY, flush_i = 1:
  - div_annul_o = 1 combinationally in that cycle.
  - Go to IDLE; no HI/LO write, even if div_ready_i = 1 in the same cycle.
- DONE: unconditionally go to IDLE; op_i is ignored (the divide instruction is still present and retiring).
- Divide by zero: no special casing; whatever the divider returns is written to HI/LO.
- stall_o = (IDLE and op is DIV/DIVU and flush_i = 0) or (BUSY and flush_i = 0).
- div_annul_o = BUSY and flush_i.
- Reset in any state: IDLE, HI = LO = 0, all outputs 0 the following cycle. An in-flight divide is dropped; the divider is reset by the same rst.

## Timing
- Let L be the number of cycles from the first cycle with div_start_o = 1 to the cycle with div_ready_i = 1.
- Accept cycle is t0 (stall_o = 1).
- BUSY occupies t1 .. t1+L with stall_o = 1.
- DONE at t2+L: stall_o = 0 and HI/LO hold the new values.
- Total stall: L+2 cycles.
- MTHI/MTLO: zero stall; the value is visible on hi_o/lo_o one cycle after the op.
- Back-to-back divides:
  - The second divide is accepted in the IDLE cycle after DONE.
  - The divider sees div_start_o low for exactly one cycle (DONE) and returns to its free state.
- hi_o/lo_o are pure register outputs. No forwarding: a reader in the same cycle as a write sees the old value.

## Structure
- Shared package/defines file:
  - Op encodings (OP_NOP, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO).
  - FSM state constants (DC_IDLE, DC_BUSY, DC_DONE).
  - The existing divider start/stop/ready constants.
- Single module. The HI/LO pair is simple enough to stay inline; no sub-module.
- The divider is instantiated by the EX-stage top, not by this block.

## Test plan
- DIVU, rs = 100, rt = 7, divider model L = 34 -> stall_o high 36 cycles; DONE gives hi_o = 2, lo_o = 14.
- DIV, rs = 0xFFFFFFF9 (-7), rt = 2 -> div_signed_o = 1; hi_o = 0xFFFFFFFF, lo_o = 0xFFFFFFFD.
- MTHI 0x12345678, then MTLO 0xCAFEBABE on consecutive cycles -> no stall; hi_o/lo_o update one cycle after each op.
- DIVU accepted, flush_i pulsed at BUSY cycle 10 -> div_annul_o = 1 that cycle; IDLE next; HI/LO unchanged; stall_o = 0.
- flush_i coincident with div_ready_i -> no HI/LO write; back to IDLE.
- rst asserted mid-BUSY, then DIVU rs = 0, rt = 0 -> all outputs 0 after reset; the divide-by-zero completes and writes the divider's returned value (0/0) to HI/LO.

Source files
------------

// File: rtl/hilo_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_div_ctrl_pkg
// Description : Shared encodings for the HI/LO + divider control block:
//               EX-stage op codes, control FSM states and the divider
//               handshake levels.
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_div_ctrl_pkg;

  // EX-stage operation encodings on op_i; 5..7 behave as NOP.
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;

  // Divide control FSM states.
  typedef enum logic [1:0] {
    DC_IDLE = 2'd0,
    DC_BUSY = 2'd1,
    DC_DONE = 2'd2
  } dc_state_e;

  // Divider handshake levels.
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage : hilo_div_ctrl_pkg
`default_nettype wire

// File: rtl/hilo_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hilo_div_ctrl_if
// Description : Bundle between the EX stage / iterative divider (master side)
//               and the HI/LO divide controller (slave side).
//   op_i, rs_i, rt_i, flush_i : EX-stage op, operands and flush
//   div_result_i, div_ready_i : divider result {rem, quo} and valid
//   div_start_o, div_annul_o  : divider start/hold and cancel
//   div_signed_o, div_op1_o/2 : latched signedness and operands
//   stall_o, hi_o, lo_o       : pipeline stall and HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
interface hilo_div_ctrl_if;

  logic [2:0]  op_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic        flush_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output op_i, rs_i, rt_i, flush_i, div_result_i, div_ready_i,
    input  div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
           stall_o, hi_o, lo_o
  );

  modport slave (
    input  op_i, rs_i, rt_i, flush_i, div_result_i, div_ready_i,
    output div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
           stall_o, hi_o, lo_o
  );

endinterface : hilo_div_ctrl_if
`default_nettype wire

// File: rtl/hilo_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hilo_div_ctrl
// Description : EX-stage control for multi-cycle DIV/DIVU and the HI/LO
//               register pair. Latches divide operands, holds the divider
//               start line while the divide is in flight, stalls the
//               pipeline, commits {rem, quo} into HI/LO and annuls the
//               divide on a pipeline flush. MTHI/MTLO write HI/LO directly.
//   clk, rst : clock, synchronous active-high reset
//   bus      : hilo_div_ctrl_if.slave (ops, divider handshake, stall, HI/LO)
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  hilo_div_ctrl_if.slave bus
);

  dc_state_e   r_state;
  dc_state_e   w_state_nxt;

  logic        w_accept;     // IDLE cycle that latches a divide
  logic        w_commit;     // BUSY cycle whose result lands in HI/LO
  logic        w_wr_hi;
  logic        w_wr_lo;
  logic        w_start;
  logic        w_annul;
  logic        w_stall;

  logic        r_signed;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DC_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    w_start     = DIV_STOP;
    w_annul     = 1'b0;
    w_stall     = 1'b0;

    case (r_state)
      DC_IDLE: begin
        if (!bus.flush_i) begin
          if (is_div_op(bus.op_i)) begin
            w_accept    = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = DC_BUSY;
          end
          w_wr_hi = (bus.op_i == OP_MTHI);
          w_wr_lo = (bus.op_i == OP_MTLO);
        end
      end

      DC_BUSY: begin
        w_start = DIV_START;
        if (bus.flush_i) begin
          // A flush wins over a same-cycle result: the divide is dropped.
          w_annul     = 1'b1;
          w_state_nxt = DC_IDLE;
        end else begin
          w_stall = 1'b1;
          if (bus.div_ready_i == DIV_RESULT_READY) begin
            w_commit    = 1'b1;
            w_state_nxt = DC_DONE;
          end
        end
      end

      DC_DONE: begin
        // The divide instruction is still retiring here, so op_i is ignored;
        // this also gives the divider one cycle of start low to rearm.
        w_state_nxt = DC_IDLE;
      end

      default: begin
        w_state_nxt = DC_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand latch and HI/LO registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_signed <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept) begin
        r_op1    <= bus.rs_i;
        r_op2    <= bus.rt_i;
        r_signed <= (bus.op_i == OP_DIV);
      end

      if (w_commit) begin
        r_hi <= bus.div_result_i[63:32];
        r_lo <= bus.div_result_i[31:0];
      end else begin
        if (w_wr_hi) begin
          r_hi <= bus.rs_i;
        end
        if (w_wr_lo) begin
          r_lo <= bus.rs_i;
        end
      end
    end
  end

  assign bus.div_start_o  = w_start;
  assign bus.div_annul_o  = w_annul;
  assign bus.div_signed_o = r_signed;
  assign bus.div_op1_o    = r_op1;
  assign bus.div_op2_o    = r_op2;
  assign bus.stall_o      = w_stall;
  assign bus.hi_o         = r_hi;
  assign bus.lo_o         = r_lo;

endmodule : hilo_div_ctrl
`default_nettype wire

// File: tb/tb_hilo_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_div_ctrl
// Description : Scoreboard bench for hilo_div_ctrl with a latency-programmable
//               divider model. The driver pushes the expected outcome of each
//               operation; a monitor pops and compares when the DUT shows it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_div_ctrl;
  import hilo_div_ctrl_pkg::*;

  localparam int K_DIV   = 0;
  localparam int K_ANNUL = 1;
  localparam int K_MT    = 2;
  localparam int K_RST   = 3;

  typedef struct {
    int          kind;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
  } exp_t;

  logic clk;
  logic rst;
  hilo_div_ctrl_if bus();

  hilo_div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  int unsigned div_lat  = 1;
  int unsigned dv_cnt;

  // Architectural divide: {remainder, quotient}; remainder takes the sign of
  // the dividend. Divide by zero returns quotient all ones, remainder = rs.
  function automatic logic [63:0] ref_div(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider model: ready after div_lat cycles of continuous start.
  always_ff @(posedge clk) begin
    if (rst || !bus.div_start_o || bus.div_annul_o) dv_cnt <= 0;
    else                                            dv_cnt <= dv_cnt + 1;
  end
  assign bus.div_ready_i  = bus.div_start_o && (dv_cnt == div_lat);
  assign bus.div_result_i = ref_div(bus.div_op1_o, bus.div_op2_o, bus.div_signed_o);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop(input int kind, output exp_t e, output bit ok);
    checks++;
    ok = 1'b0;
    e  = '{kind: -1, hi: '0, lo: '0, stall: 0};
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual=kind%0d required=none at %0t", kind, $time);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("FAIL event_kind actual=%0d required=%0d at %0t", kind, e.kind, $time);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  initial begin
    exp_t e;
    bit   ok;
    int   run    = 0;
    bit   p_stall = 1'b0;
    bit   p_rst   = 1'b0;
    bit   mt_p    = 1'b0;
    bit   an_p    = 1'b0;
    forever begin
      @(negedge clk);
      if (p_rst && !rst) begin
        pop(K_RST, e, ok);
        if (ok) begin
          chk("rst_hi",     bus.hi_o,         64'd0);
          chk("rst_lo",     bus.lo_o,         64'd0);
          chk("rst_start",  bus.div_start_o,  64'd0);
          chk("rst_annul",  bus.div_annul_o,  64'd0);
          chk("rst_signed", bus.div_signed_o, 64'd0);
          chk("rst_op1",    bus.div_op1_o,    64'd0);
          chk("rst_op2",    bus.div_op2_o,    64'd0);
          chk("rst_stall",  bus.stall_o,      64'd0);
        end
      end
      if (mt_p && !rst) begin
        pop(K_MT, e, ok);
        if (ok) begin
          chk("mt_hi", bus.hi_o, e.hi);
          chk("mt_lo", bus.lo_o, e.lo);
        end
      end
      if (an_p && !rst) begin
        pop(K_ANNUL, e, ok);
        if (ok) begin
          chk("annul_hi",    bus.hi_o,    e.hi);
          chk("annul_lo",    bus.lo_o,    e.lo);
          chk("annul_stall", bus.stall_o, 64'd0);
        end
      end
      mt_p = 1'b0;
      an_p = 1'b0;
      if (!rst) begin
        if (bus.div_annul_o) begin
          an_p = 1'b1;
        end else if (p_stall && !bus.stall_o && !p_rst) begin
          pop(K_DIV, e, ok);
          if (ok) begin
            chk("div_hi",    bus.hi_o, e.hi);
            chk("div_lo",    bus.lo_o, e.lo);
            chk("div_stall", run,      e.stall);
          end
        end
        if (!bus.flush_i && !bus.stall_o &&
            (bus.op_i == OP_MTHI || bus.op_i == OP_MTLO)) mt_p = 1'b1;
      end
      run     = (bus.stall_o && !rst) ? run + 1 : 0;
      p_stall = bus.stall_o;
      p_rst   = rst;
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.op_i    = OP_NOP;
    bus.flush_i = 1'b0;
    repeat (n) step();
  endtask

  // Issue a divide; flush_at < 0 lets it complete, otherwise flush on that
  // BUSY cycle (0-based). Returns in the IDLE cycle after DONE/annul.
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned lat, input int flush_at);
    logic [63:0] r;
    int          n;
    div_lat     = lat;
    bus.op_i    = sgn ? OP_DIV : OP_DIVU;
    bus.rs_i    = a;
    bus.rt_i    = b;
    bus.flush_i = 1'b0;
    if (flush_at < 0) begin
      r        = ref_div(a, b, sgn);
      model_hi = r[63:32];
      model_lo = r[31:0];
      sb.push_back('{kind: K_DIV, hi: model_hi, lo: model_lo, stall: int'(lat) + 2});
    end else begin
      sb.push_back('{kind: K_ANNUL, hi: model_hi, lo: model_lo, stall: 0});
    end
    step();
    if (flush_at >= 0) begin
      repeat (flush_at) step();
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      bus.op_i    = OP_NOP;
    end else begin
      n = 0;
      while (bus.stall_o && n < 300) begin
        step();
        n++;
      end
      if (bus.stall_o) begin
        checks++;
        errors++;
        $display("FAIL div_timeout actual=stall_high required=stall_low at %0t", $time);
      end
      step();
      bus.op_i = OP_NOP;
    end
  endtask

  task automatic do_mt(input bit is_hi, input logic [31:0] d);
    bus.op_i    = is_hi ? OP_MTHI : OP_MTLO;
    bus.rs_i    = d;
    bus.flush_i = 1'b0;
    if (is_hi) model_hi = d;
    else       model_lo = d;
    sb.push_back('{kind: K_MT, hi: model_hi, lo: model_lo, stall: 0});
    step();
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    bus.op_i = OP_NOP;
    model_hi = '0;
    model_lo = '0;
    sb.push_back('{kind: K_RST, hi: '0, lo: '0, stall: 0});
    repeat (n) step();
    rst = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    rst         = 1'b1;
    bus.op_i    = OP_NOP;
    bus.rs_i    = '0;
    bus.rt_i    = '0;
    bus.flush_i = 1'b0;
    #1;
    do_reset(3);
    idle(2);

    do_div(1'b0, 32'd100, 32'd7, 34, -1);
    idle(1);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 5, -1);
    do_mt(1'b1, 32'h1234_5678);
    do_mt(1'b0, 32'hCAFE_BABE);
    idle(2);
    do_div(1'b0, 32'd1000, 32'd3, 34, 10);
    idle(1);
    do_div(1'b0, 32'd55, 32'd6, 6, 6);
    idle(1);
    // Back-to-back divides
    do_div(1'b0, 32'd77, 32'd10, 4, -1);
    do_div(1'b1, 32'h8000_0000, 32'd3, 3, -1);
    idle(1);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      int unsigned lat;
      a   = $urandom;
      b   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      lat = $urandom_range(1, 12);
      case ($urandom_range(0, 4))
        0: do_div($urandom_range(0, 1) == 1, a, b, lat, -1);
        1: do_div($urandom_range(0, 1) == 1, a, b, lat, int'($urandom_range(0, lat)));
        2: do_mt($urandom_range(0, 1) == 1, a);
        3: begin
          // Flushed ops in IDLE must leave everything untouched.
          bus.op_i    = 3'($urandom_range(1, 4));
          bus.rs_i    = a;
          bus.rt_i    = b;
          bus.flush_i = 1'b1;
          step();
          bus.flush_i = 1'b0;
          bus.op_i    = OP_NOP;
        end
        default: begin
          bus.op_i = 3'($urandom_range(5, 7));
          bus.rs_i = a;
          step();
          bus.op_i = OP_NOP;
        end
      endcase
      idle($urandom_range(0, 2));
    end

    // Reset mid-BUSY, then a divide by zero.
    div_lat     = 20;
    bus.op_i    = OP_DIVU;
    bus.rs_i    = 32'd5;
    bus.rt_i    = 32'd3;
    step();
    repeat (5) step();
    do_reset(1);
    idle(1);
    do_div(1'b0, 32'd0, 32'd0, 8, -1);
    idle(4);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_hilo_div_ctrl
`default_nettype wire
